ccd_phase_gen: RTL and testbench

CCD_PHASE_GEN -- requirements
Module: ccd_phase_gen

---
 rtl/ccd_phase_pkg.sv | 25 ++
 rtl/ccd_phase_gen_if.sv | 37 +++
 rtl/ccd_phase_chan.sv | 83 ++++++++
 rtl/ccd_phase_gen.sv | 126 ++++++++++++
 tb/tb_ccd_phase_gen.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ccd_phase_pkg.sv
// ccd_phase_pkg -- shared definitions for the CCD phase-clock generator.
//   state_t     : controller states (IDLE / RUN / STOPPING)
//   addr_w()    : config address width, max(1, clog2(num_ch+1))
//   period_addr(): config address that selects the period register
package ccd_phase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  // Lock counter width; LOCK_PERIODS is limited to 1..255.
  localparam int LOCK_W = 8;

  function automatic int addr_w(input int num_ch);
    return ($clog2(num_ch + 1) > 1) ? $clog2(num_ch + 1) : 1;
  endfunction

  // Channels occupy addresses 0..num_ch-1; the period register sits right after.
  function automatic int period_addr(input int num_ch);
    return num_ch;
  endfunction

endpackage

// File: rtl/ccd_phase_gen_if.sv
// ccd_phase_gen_if -- control, config handshake and phase outputs of the
// generator.
//   start/stop         : single-cycle run requests
//   cfg_valid/cfg_ready: config write handshake; cfg_addr/cfg_rise/cfg_fall/cfg_idle carry the write
//   phi                : phase clocks, one bit per channel
//   sync               : one-cycle pulse at the start of each period
//   running/locked     : status; rst_out is the downstream reset (registered !locked)
// modport master drives the requests, modport slave is the generator side.
interface ccd_phase_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int AW     = ccd_phase_pkg::addr_w(NUM_CH)
);
  logic              start;
  logic              stop;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [AW-1:0]     cfg_addr;
  logic [CNT_W-1:0]  cfg_rise;
  logic [CNT_W-1:0]  cfg_fall;
  logic              cfg_idle;
  logic [NUM_CH-1:0] phi;
  logic              sync;
  logic              running;
  logic              locked;
  logic              rst_out;

  modport master (
    output start, stop, cfg_valid, cfg_addr, cfg_rise, cfg_fall, cfg_idle,
    input  cfg_ready, phi, sync, running, locked, rst_out
  );

  modport slave (
    input  start, stop, cfg_valid, cfg_addr, cfg_rise, cfg_fall, cfg_idle,
    output cfg_ready, phi, sync, running, locked, rst_out
  );
endinterface

// File: rtl/ccd_phase_chan.sv
// ccd_phase_chan -- one phase-clock channel.
//   wr_i/wr_rise_i/wr_fall_i/wr_idle_i : shadow register write
//   apply_i/period_i                   : copy shadow to active, clamping edges to period_i
//   cnt_i/running_i                    : period counter and run status from the parent
//   phi_o                              : registered phase clock (one cycle behind cnt_i)
module ccd_phase_chan #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_rise_i,
  input  logic [CNT_W-1:0] wr_fall_i,
  input  logic             wr_idle_i,
  input  logic             apply_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             running_i,
  output logic             phi_o
);

  logic [CNT_W-1:0] sh_rise_q, sh_rise_d, sh_fall_q, sh_fall_d;
  logic [CNT_W-1:0] rise_q, rise_d, fall_q, fall_d;
  logic             sh_idle_q, sh_idle_d, idle_q, idle_d;
  logic             phi_q, phi_d;
  logic             act;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sh_rise_d = sh_rise_q;
    sh_fall_d = sh_fall_q;
    sh_idle_d = sh_idle_q;
    rise_d    = rise_q;
    fall_d    = fall_q;
    idle_d    = idle_q;
    act       = 1'b0;

    if (wr_i) begin
      sh_rise_d = wr_rise_i;
      sh_fall_d = wr_fall_i;
      sh_idle_d = wr_idle_i;
    end

    // The shadow keeps the raw value; only the active copy is clamped, so a
    // later longer period re-exposes more of the programmed edge.
    if (apply_i) begin
      rise_d = (sh_rise_q > period_i) ? period_i : sh_rise_q;
      fall_d = (sh_fall_q > period_i) ? period_i : sh_fall_q;
      idle_d = sh_idle_q;
    end

    // rise > fall is a window that wraps through the period boundary.
    if (rise_q < fall_q)      act = (cnt_i >= rise_q) && (cnt_i < fall_q);
    else if (rise_q > fall_q) act = (cnt_i >= rise_q) || (cnt_i < fall_q);

    phi_d = running_i ? (idle_q ^ act) : idle_q;
  end

  // NOTE: shadow and active edge registers are small flops, so they are reset along with control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_rise_q <= '0;
      sh_fall_q <= '0;
      sh_idle_q <= 1'b0;
      rise_q    <= '0;
      fall_q    <= '0;
      idle_q    <= 1'b0;
      phi_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      sh_rise_q <= sh_rise_d;
      sh_fall_q <= sh_fall_d;
      sh_idle_q <= sh_idle_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      idle_q    <= idle_d;
      phi_q     <= phi_d;
    end
  end

  assign phi_o = phi_q;

endmodule

// File: rtl/ccd_phase_gen.sv
// ccd_phase_gen -- programmable multi-channel CCD phase-clock generator.
//   clk, rst : single clock, asynchronous active-high reset
//   bus      : ccd_phase_gen_if.slave (start/stop, config handshake, phi/sync/status)
// Holds the run FSM, period counter, active/shadow period, update handshake
// and lock tracking; per-channel edge logic lives in ccd_phase_chan.
module ccd_phase_gen import ccd_phase_pkg::*; #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 8,
  parameter int LOCK_PERIODS = 4,
  parameter int AW           = addr_w(NUM_CH)
) (
  input logic            clk,
  input logic            rst,
  ccd_phase_gen_if.slave bus
);

  localparam logic [AW-1:0]     PERIOD_ADDR = AW'(period_addr(NUM_CH));
  localparam logic [LOCK_W-1:0] LOCK_TGT    = LOCK_W'(LOCK_PERIODS);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    period_q, period_d, sh_period_q, sh_period_d;
  logic                pending_q, pending_d, pend_per_q, pend_per_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                locked_q, locked_d, rst_out_q, sync_q, sync_d;
  logic                ready_en_q;
  logic                run, tc, wr_acc, wr_period, apply;
  logic [NUM_CH-1:0]   phi;

  assign run       = (state_q != ST_IDLE);
  assign tc        = run && (cnt_q == period_q);
  assign wr_acc    = bus.cfg_valid && bus.cfg_ready;
  assign wr_period = wr_acc && (bus.cfg_addr == PERIOD_ADDR);
  // pending_q is registered, so a write taken on a terminal count waits for the next one.
  assign apply     = pending_q && ((state_q == ST_IDLE) || tc);

  always_comb begin
    state_d     = state_q;
    cnt_d       = (!run || tc) ? '0 : cnt_q + CNT_W'(1);
    sync_d      = (state_q == ST_RUN) && (cnt_q == '0);
    sh_period_d = sh_period_q;
    period_d    = apply ? sh_period_q : period_q;
    pending_d   = pending_q;
    pend_per_d  = pend_per_q;
    lock_cnt_d  = lock_cnt_q;
    locked_d    = locked_q;

    case (state_q)
      ST_IDLE:     if (bus.start && !bus.stop) state_d = ST_RUN;
      ST_RUN:      if (bus.stop) state_d = ST_STOPPING;
      ST_STOPPING: if (tc) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    if (apply) begin
      pending_d  = 1'b0;
      pend_per_d = 1'b0;
    end
    if (wr_acc) begin
      pending_d  = 1'b1;
      pend_per_d = wr_period;
    end
    // A zero period would never leave cnt==0, so it is stored as 1.
    if (wr_period) sh_period_d = (bus.cfg_rise == '0) ? CNT_W'(1) : bus.cfg_rise;

    if ((state_q == ST_IDLE) || (state_q == ST_RUN && bus.stop) || (apply && pend_per_q)) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else if ((state_q == ST_RUN) && tc && !locked_q) begin
      lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      if (lock_cnt_d == LOCK_TGT) locked_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      period_q    <= CNT_W'(1);
      sh_period_q <= CNT_W'(1);
      pending_q   <= 1'b0;
      pend_per_q  <= 1'b0;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      rst_out_q   <= 1'b1;
      sync_q      <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      sh_period_q <= sh_period_d;
      pending_q   <= pending_d;
      pend_per_q  <= pend_per_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
      rst_out_q   <= ~locked_q;
      sync_q      <= sync_d;
      ready_en_q  <= 1'b1;   // holds cfg_ready low until the first edge after reset
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    ccd_phase_chan #(.CNT_W(CNT_W)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .wr_i      (wr_acc && (bus.cfg_addr == AW'(i))),
      .wr_rise_i (bus.cfg_rise),
      .wr_fall_i (bus.cfg_fall),
      .wr_idle_i (bus.cfg_idle),
      .apply_i   (apply),
      .period_i  (period_d),
      .cnt_i     (cnt_q),
      .running_i (run),
      .phi_o     (phi[i])
    );
  end

  assign bus.cfg_ready = ready_en_q && !pending_q;
  assign bus.phi       = phi;
  assign bus.sync      = sync_q;
  assign bus.running   = run;
  assign bus.locked    = locked_q;
  assign bus.rst_out   = rst_out_q;

endmodule

// File: tb/tb_ccd_phase_gen.sv
// tb_ccd_phase_gen -- directed bench for ccd_phase_gen (NUM_CH=4, CNT_W=8,
// LOCK_PERIODS=4). Inputs change and outputs are sampled on the falling edge.
module tb_ccd_phase_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  ccd_phase_gen_if #(.NUM_CH(4), .CNT_W(8)) bus ();

  ccd_phase_gen #(.NUM_CH(4), .CNT_W(8), .LOCK_PERIODS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.cfg_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("ready_wait", bus.cfg_ready, 1);
  endtask

  task automatic cfg_write(input int a, input int r, input int f, input bit idl);
    int n;
    wait_ready(n);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 3'(a);
    bus.cfg_rise  = 8'(r);
    bus.cfg_fall  = 8'(f);
    bus.cfg_idle  = idl;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   c, n;
    logic e0, e1, e2;
    bus.start = 0; bus.stop = 0; bus.cfg_valid = 0;
    bus.cfg_addr = '0; bus.cfg_rise = '0; bus.cfg_fall = '0; bus.cfg_idle = 0;

    // Reset values, before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_phi", bus.phi, 0);
    check("rst_sync", bus.sync, 0);
    check("rst_running", bus.running, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_rst_out", bus.rst_out, 1);
    check("rst_ready", bus.cfg_ready, 0);
    tick(); tick();
    rst = 1'b0;
    #1 check("ready_in_release", bus.cfg_ready, 0);
    tick();
    check("ready_after_rst", bus.cfg_ready, 1);

    // A: period 9, ch0 2/6 idle 0, ch1 8/3 idle 1
    cfg_write(4, 9, 0, 0);
    cfg_write(0, 2, 6, 0);
    cfg_write(1, 8, 3, 1);
    wait_ready(n);
    bus.start = 1; tick(); bus.start = 0;
    check("a_running", bus.running, 1);
    check("a_phi_idle", bus.phi, 4'b0010);
    for (int k = 1; k <= 42; k++) begin
      tick();
      c  = (k - 1) % 10;
      e0 = (c >= 2 && c < 6);
      e1 = !(c >= 8 || c < 3);
      check("a_phi", bus.phi, {2'b00, e1, e0});
      check("a_sync", bus.sync, (c == 0));
      check("a_locked", bus.locked, (k >= 40));
      check("a_rst_out", bus.rst_out, (k < 41));
    end

    // B: ch1 rise=fall=5 while locked -> phi[1] constant 1, lock kept
    cfg_write(1, 5, 5, 1);
    wait_ready(n);
    check("b_wait", n, 7);
    for (int k = 51; k <= 60; k++) begin
      tick();
      c = (k - 1) % 10;
      check("b_phi", bus.phi, {2'b00, 1'b1, (c >= 2 && c < 6)});
      check("b_locked", bus.locked, 1);
    end

    // C: period 19 written at cnt=3
    tick(); tick(); tick();
    cfg_write(4, 19, 0, 0);
    check("c_ready_low", bus.cfg_ready, 0);
    wait_ready(n);
    check("c_wait", n, 6);
    check("c_locked_drop", bus.locked, 0);
    for (int j = 1; j <= 81; j++) begin
      tick();
      c = (j - 1) % 20;
      check("c_phi", bus.phi, {2'b00, 1'b1, (c >= 2 && c < 6)});
      check("c_sync", bus.sync, (c == 0));
      check("c_locked", bus.locked, (j >= 80));
      check("c_rst_out", bus.rst_out, (j < 81));
    end

    // D: stop at cnt=3, generation continues to cnt=19 then idles
    tick(); tick();
    bus.stop = 1; tick(); bus.stop = 0;
    for (int j = 84; j <= 101; j++) begin
      if (j > 84) tick();
      c  = (j - 1) % 20;
      e0 = (j <= 100) && (c >= 2 && c < 6);
      check("d_running", bus.running, (j < 100));
      check("d_phi", bus.phi, {2'b00, 1'b1, e0});
      check("d_sync", bus.sync, 0);
      check("d_locked", bus.locked, 0);
    end

    // E: start and stop together in IDLE
    bus.start = 1; bus.stop = 1; tick(); bus.start = 0; bus.stop = 0;
    check("e_running", bus.running, 0);
    tick();
    check("e_running2", bus.running, 0);
    check("e_sync", bus.sync, 0);

    // F: clamping with period 9 (ch0 fall=200, ch2 rise=200 fall=3)
    cfg_write(4, 9, 0, 0);
    cfg_write(0, 2, 200, 0);
    cfg_write(2, 200, 3, 0);
    wait_ready(n);
    bus.start = 1; tick(); bus.start = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      c  = (k - 1) % 10;
      e2 = (c == 9 || c <= 2);
      if (c != 9) check("f_ch0", bus.phi[0], (c >= 2));
      check("f_ch1", bus.phi[1], 1);
      check("f_ch2", bus.phi[2], e2);
    end

    // G: reset mid-period with a period write pending
    tick(); tick(); tick();
    cfg_write(4, 4, 0, 0);
    check("g_pending", bus.cfg_ready, 0);
    rst = 1'b1;
    #1;
    check("g_phi", bus.phi, 0);
    check("g_sync", bus.sync, 0);
    check("g_running", bus.running, 0);
    check("g_locked", bus.locked, 0);
    check("g_rst_out", bus.rst_out, 1);
    check("g_ready", bus.cfg_ready, 0);
    tick();
    check("g_ready_hold", bus.cfg_ready, 0);
    rst = 1'b0;
    tick();
    check("g_ready_rise", bus.cfg_ready, 1);
    // Period must still be the reset value 1: cnt alternates 0,1
    cfg_write(0, 0, 1, 0);
    wait_ready(n);
    bus.start = 1; tick(); bus.start = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      c = (k - 1) % 2;
      check("g_phi_p1", bus.phi, {3'b000, (c == 0)});
      check("g_sync_p1", bus.sync, (c == 0));
    end

    // H: programmed period 0 behaves as period 1
    bus.stop = 1; tick(); bus.stop = 0;
    n = 0;
    while (bus.running === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("h_stopped", bus.running, 0);
    cfg_write(4, 0, 0, 0);
    wait_ready(n);
    bus.start = 1; tick(); bus.start = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("h_phi_p0", bus.phi[0], ((k - 1) % 2 == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
